// File: rtl/sparsity_density_sampler_if.sv
// Observed stream beat plus the sample record that goes out to the adaptive FSM.
// The sampler is a passive tap, so the stream signals are inputs on both sides except for the stream source.
interface sparsity_density_sampler_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    sample_valid;
  logic [15:0]             nonzero_count;
  logic [15:0]             total_count;

  modport master (output in_valid, in_ready, in_data,
                  input  sample_valid, nonzero_count, total_count);
  modport slave  (input  in_valid, in_ready, in_data,
                  output sample_valid, nonzero_count, total_count);
endinterface

// File: rtl/sparsity_density_sampler.sv
// Passive sparsity tap: counts near-zero elements per accepted beat and reports
// nonzero/total element counts once per SAMPLE_BEATS beats, with skip duty-cycling and flush.

module sds_lane #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-2:0] thresh,
  output logic              nz
);
  logic [DATA_W:0] ext, mag;
  // One extra bit so the most negative value keeps a magnitude above any threshold
  assign ext = {x[DATA_W-1], x};
  assign mag = x[DATA_W-1] ? (~ext + (DATA_W+1)'(1)) : ext;
  assign nz  = mag > {2'b00, thresh};
endmodule

module sparsity_density_sampler #(
  parameter int LANES        = 16,
  parameter int DATA_W       = 8,
  parameter int SAMPLE_BEATS = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [DATA_W-2:0]             zero_thresh,
  input  logic [7:0]                    skip_beats,
  input  logic                          flush,
  output logic                          overflow_flag,
  sparsity_density_sampler_if.slave     bus
);
  localparam int PW = $clog2(LANES + 1);
  localparam int BW = (SAMPLE_BEATS > 1) ? $clog2(SAMPLE_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, SKIP} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   beat_cnt, beat_cnt_nx;
  logic [7:0]      skip_cnt, skip_cnt_nx;
  logic            hs, capture, close, flush_fire;
  logic [LANES-1:0] lane_nz;
  logic [PW-1:0]   pop;

  // Stage 1 and stage 2 state
  logic            beat_s1, close_s1;
  logic [PW-1:0]   pop_s1;
  logic [15:0]     nz_acc, tot_acc;
  logic [16:0]     nz_sum, tot_sum;
  logic [15:0]     nz_sat, tot_sat;
  logic            sat_hit;
  logic            sample_valid_q;
  logic [15:0]     nz_out, tot_out;

  assign hs = bus.in_valid && bus.in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sds_lane #(.DATA_W(DATA_W)) u_lane (
      .x      (bus.in_data[i*DATA_W +: DATA_W]),
      .thresh (zero_thresh),
      .nz     (lane_nz[i])
    );
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) pop = pop + PW'(lane_nz[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      beat_cnt <= '0;
      skip_cnt <= '0;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
      skip_cnt <= skip_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    skip_cnt_nx = skip_cnt;
    capture     = 1'b0;
    close       = 1'b0;
    flush_fire  = 1'b0;
    if (!enable) begin
      state_nx    = IDLE;
      beat_cnt_nx = '0;
      skip_cnt_nx = '0;
    end else begin
      case (state)
        IDLE:  state_nx = ACCUM;
        ACCUM: begin
          capture    = hs;
          // beat_cnt counts everything since the last close, whether still in the pipe or accumulated
          flush_fire = flush && (hs || beat_cnt != '0);
          close      = (hs && beat_cnt == BW'(SAMPLE_BEATS - 1)) || flush_fire;
          if (hs) beat_cnt_nx = beat_cnt + BW'(1);
          if (close) begin
            beat_cnt_nx = '0;
            skip_cnt_nx = skip_beats;
            state_nx    = (skip_beats != 8'd0) ? SKIP : ACCUM;
          end
        end
        SKIP: begin
          if (hs) begin
            skip_cnt_nx = skip_cnt - 8'd1;
            if (skip_cnt == 8'd1) state_nx = ACCUM;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_s1  <= 1'b0;
      close_s1 <= 1'b0;
      pop_s1   <= '0;
    end else if (!enable) begin
      beat_s1  <= 1'b0;
      close_s1 <= 1'b0;
      pop_s1   <= '0;
    end else begin
      beat_s1  <= capture;
      close_s1 <= close;
      if (capture) pop_s1 <= pop;
    end
  end

  // A flush with no beat on its edge travels as a close marker with beat_s1 low
  assign nz_sum  = {1'b0, nz_acc}  + (beat_s1 ? 17'(pop_s1) : 17'd0);
  assign tot_sum = {1'b0, tot_acc} + (beat_s1 ? 17'(LANES)  : 17'd0);
  assign nz_sat  = nz_sum[16]  ? 16'hFFFF : nz_sum[15:0];
  assign tot_sat = tot_sum[16] ? 16'hFFFF : tot_sum[15:0];
  assign sat_hit = nz_sum[16] || tot_sum[16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nz_acc         <= '0;
      tot_acc        <= '0;
      sample_valid_q <= 1'b0;
      nz_out         <= '0;
      tot_out        <= '0;
      overflow_flag  <= 1'b0;
    end else if (!enable) begin
      nz_acc         <= '0;
      tot_acc        <= '0;
      sample_valid_q <= 1'b0;
      overflow_flag  <= 1'b0;
    end else begin
      sample_valid_q <= close_s1;
      if (sat_hit) overflow_flag <= 1'b1;
      if (close_s1) begin
        nz_out  <= nz_sat;
        tot_out <= tot_sat;
        nz_acc  <= '0;
        tot_acc <= '0;
      end else begin
        nz_acc  <= nz_sat;
        tot_acc <= tot_sat;
      end
    end
  end

  assign bus.sample_valid  = sample_valid_q;
  assign bus.nonzero_count = nz_out;
  assign bus.total_count   = tot_out;
endmodule

// File: tb/tb_sparsity_density_sampler.sv
// Directed bench for sparsity_density_sampler: expected records are queued as stimulus
// is driven and popped by a monitor whenever sample_valid pulses.
module tb_sparsity_density_sampler;
  localparam int LANES = 16;
  localparam int DATA_W = 8;
  localparam int W = LANES * DATA_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [DATA_W-2:0] zero_thresh = '0;
  logic [7:0] skip_beats = '0;
  logic flush = 1'b0;
  logic overflow_flag;

  sparsity_density_sampler_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

  sparsity_density_sampler #(.LANES(LANES), .DATA_W(DATA_W), .SAMPLE_BEATS(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .zero_thresh   (zero_thresh),
    .skip_beats    (skip_beats),
    .flush         (flush),
    .overflow_flag (overflow_flag),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  logic [31:0] exp_q[$];
  int pulse_at[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Record monitor
  always @(negedge clk) begin
    if (!reset && bus.sample_valid) begin
      pulses++;
      pulse_at.push_back(cyc);
      chk("record_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0)
        chk("record", {bus.nonzero_count, bus.total_count}, exp_q.pop_front());
    end
  end

  function automatic logic [W-1:0] mk(input int k, input logic [7:0] v);
    logic [W-1:0] d = '0;
    for (int i = 0; i < LANES; i++) if (i < k) d[i*DATA_W +: DATA_W] = v;
    return d;
  endfunction

  function automatic int count_nz(input logic [W-1:0] d, input int thr);
    int n = 0;
    for (int i = 0; i < LANES; i++) begin
      int x;
      x = int'($signed(d[i*DATA_W +: DATA_W]));
      if (x < 0) x = -x;
      if (x > thr) n++;
    end
    return n;
  endfunction

  task automatic push(input int nz, input int tot);
    exp_q.push_back({16'(nz), 16'(tot)});
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_ready = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    bus.in_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin step(); n++; end
    repeat (3) step();
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_cycle();
    enable = 1'b0;
    step();
    enable = 1'b1;
    step();
  endtask

  initial begin
    int last, p, e1, e2;
    logic [W-1:0] d;
    bus.in_valid = 1'b0;
    bus.in_ready = 1'b0;
    bus.in_data  = '0;
    repeat (2) step();
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_nz", 32'(bus.nonzero_count), 32'd0);
    chk("rst_tot", 32'(bus.total_count), 32'd0);
    chk("rst_ovf", 32'(overflow_flag), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    step();

    // all-zero sample, latency of two edges from the closing beat
    pulse_at.delete();
    push(0, 256);
    repeat (16) send('0);
    last = cyc;
    drain("t1_drain");
    chk("t1_pulses", 32'(pulse_at.size()), 32'd1);
    if (pulse_at.size() != 0) chk("t1_latency", 32'(pulse_at[0]), 32'(last + 1));

    // half-dense, back-to-back samples
    pulse_at.delete();
    push(128, 256);
    push(128, 256);
    repeat (32) send(mk(8, 8'd5));
    drain("t2_drain");
    chk("t2_pulses", 32'(pulse_at.size()), 32'd2);
    if (pulse_at.size() == 2) chk("t2_spacing", 32'(pulse_at[1] - pulse_at[0]), 32'd16);

    // threshold and the most negative value
    zero_thresh = 7'd3;
    d = '0;
    d[7:0] = 8'd3; d[15:8] = 8'hFD; d[23:16] = 8'd4; d[31:24] = 8'hFC; d[39:32] = 8'h80;
    push(48, 256);
    repeat (16) send(d);
    drain("t3_drain");
    zero_thresh = 7'd0;

    // skip 4 beats between samples
    skip_beats = 8'd4;
    e1 = 0; e2 = 0;
    for (int i = 0; i < 16; i++) e1 += count_nz(mk(i % 17, 8'd1), 0);
    for (int i = 20; i < 36; i++) e2 += count_nz(mk(i % 17, 8'd1), 0);
    push(e1, 256);
    push(e2, 256);
    pulse_at.delete();
    for (int i = 0; i < 40; i++) send(mk(i % 17, 8'd1));
    drain("t4_drain");
    chk("t4_pulses", 32'(pulse_at.size()), 32'd2);
    skip_beats = 8'd0;
    idle_cycle();

    // partial flush, empty flush, flush on the closing beat
    push(80, 80);
    repeat (5) send(mk(16, 8'd1));
    flush = 1'b1; step(); flush = 1'b0;
    drain("t5_partial");
    p = pulses;
    repeat (2) step();
    flush = 1'b1; step(); flush = 1'b0;
    repeat (5) step();
    chk("t5_empty_flush", 32'(pulses), 32'(p));
    push(256, 256);
    repeat (15) send(mk(16, 8'd1));
    flush = 1'b1; send(mk(16, 8'd1)); flush = 1'b0;
    drain("t5_close_flush");
    chk("t5_single", 32'(pulses), 32'(p + 1));

    // valid without ready is not a beat
    bus.in_valid = 1'b1; bus.in_ready = 1'b0; bus.in_data = mk(16, 8'd9);
    repeat (10) step();
    bus.in_valid = 1'b0;
    push(0, 256);
    repeat (16) send('0);
    drain("t6_noready");

    // enable drop mid-sample discards the partial sample
    repeat (8) send(mk(16, 8'd1));
    p = pulses;
    idle_cycle();
    repeat (3) step();
    chk("t6_enable_drop", 32'(pulses), 32'(p));
    push(0, 256);
    repeat (16) send('0);
    drain("t6_after_enable");

    // reset mid-sample
    repeat (8) send(mk(16, 8'd1));
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("t6_rst_nz", 32'(bus.nonzero_count), 32'd0);
    chk("t6_rst_tot", 32'(bus.total_count), 32'd0);
    chk("t6_rst_ovf", 32'(overflow_flag), 32'd0);
    step();
    reset = 1'b0;
    step();
    push(128, 256);
    repeat (16) send(mk(8, 8'd1));
    drain("t6_after_reset");
    chk("final_ovf", 32'(overflow_flag), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
